// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit.
// Op encodings follow the extended ALUControl codes.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'h0,
        OP_MULTU = 4'h1,
        OP_MADD  = 4'h2,
        OP_MADDU = 4'h3,
        OP_MSUB  = 4'h4,
        OP_MSUBU = 4'h5,
        OP_DIV   = 4'h6,
        OP_DIVU  = 4'h7,
        OP_MTHI  = 4'h8,
        OP_MTLO  = 4'h9
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DIV_CYCLES = DEF_WIDTH + 1;

    function automatic int divCycles(input int w);
        return w + 1;
    endfunction

    function automatic logic isMulOp(input op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD,
                          OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic isDivOp(input op_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic isSignedOp(input op_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic isAccOp(input op_t op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic isSubOp(input op_t op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per step; sign handling lives in the parent.
module muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             lastStep
);

    localparam int CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CntW-1:0]  cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // Load magnitudes, then shift in one quotient bit per step
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
            cnt <= '0;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign lastStep  = (cnt == LastCnt);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Busy/Done handshake toward hazard detection, Flush from MEM.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  op_t              Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int MulCntW = $clog2(MUL_LATENCY + 1);
    localparam logic [MulCntW-1:0] MulLast = MulCntW'(MUL_LATENCY - 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    op_t                  opReg;
    logic [WIDTH-1:0]     aReg;
    logic [WIDTH-1:0]     bReg;
    logic [2*WIDTH-1:0]   mulA;
    logic [2*WIDTH-1:0]   mulB;
    logic [2*WIDTH-1:0]   prodComb;
    logic [2*WIDTH-1:0]   prodOut;
    logic [2*WIDTH-1:0]   accBase;
    logic [2*WIDTH-1:0]   mulRes;
    logic [MulCntW-1:0]   mulCnt;

    logic                 accept;
    logic                 opSigned;
    logic [WIDTH-1:0]     aMag;
    logic [WIDTH-1:0]     bMag;
    logic [2*WIDTH-1:0]   aExt;
    logic [2*WIDTH-1:0]   bExt;

    logic                 divLoad;
    logic                 divStep;
    logic                 divLast;
    logic [WIDTH-1:0]     qMag;
    logic [WIDTH-1:0]     rMag;

    logic                 fixSigned;
    logic                 negQ;
    logic                 negR;
    logic [WIDTH-1:0]     fixHi;
    logic [WIDTH-1:0]     fixLo;

    // Accept decode and operand conditioning for both datapaths
    always_comb begin
        accept   = (state == IDLE) && Start && !Flush;
        opSigned = isSignedOp(Op);
        aMag     = (opSigned && OpA[WIDTH-1]) ? (~OpA + 1'b1) : OpA;
        bMag     = (opSigned && OpB[WIDTH-1]) ? (~OpB + 1'b1) : OpB;
        aExt     = opSigned ? {{WIDTH{OpA[WIDTH-1]}}, OpA}
                            : {{WIDTH{1'b0}}, OpA};
        bExt     = opSigned ? {{WIDTH{OpB[WIDTH-1]}}, OpB}
                            : {{WIDTH{1'b0}}, OpB};
        divLoad  = accept && isDivOp(Op);
        divStep  = (state == DIV) && !Flush;
    end

    muldiv_div_iter #(
        .WIDTH(WIDTH)
    ) divCore (
        .clk      (Clk),
        .rstN     (Reset),
        .load     (divLoad),
        .step     (divStep),
        .dividend (aMag),
        .divisor  (bMag),
        .quotient (qMag),
        .remainder(rMag),
        .lastStep (divLast)
    );

    // Single multiplier; low 2W bits of the extended product
    assign prodComb = mulA * mulB;

    if (MUL_LATENCY == 1) begin : gNoPipe
        assign prodOut = prodComb;
    end else begin : gPipe
        logic [2*WIDTH-1:0] stage [MUL_LATENCY-1];

        // Product pipeline; only one op is ever in flight
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= prodComb;
                for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign prodOut = stage[MUL_LATENCY-2];
    end

    // Accumulate against HI/LO as they stand at completion
    always_comb begin
        accBase = isAccOp(opReg) ? {Hi, Lo} : '0;
        mulRes  = isSubOp(opReg) ? (accBase - prodOut)
                                 : (accBase + prodOut);
    end

    // Sign fix-up and divide special cases
    always_comb begin
        fixSigned = isSignedOp(opReg);
        negQ      = fixSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
        negR      = fixSigned && aReg[WIDTH-1];
        fixLo     = negQ ? (~qMag + 1'b1) : qMag;
        fixHi     = negR ? (~rMag + 1'b1) : rMag;
        if (bReg == '0) begin
            fixLo = '1;
            fixHi = aReg;
        end else if (fixSigned && aReg == MinVal && bReg == '1) begin
            fixLo = MinVal;
            fixHi = '0;
        end
    end

    // Control FSM with registered HI/LO, Busy and Done
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            opReg  <= OP_MULT;
            aReg   <= '0;
            bReg   <= '0;
            mulA   <= '0;
            mulB   <= '0;
            mulCnt <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            opReg  <= Op;
                            aReg   <= OpA;
                            bReg   <= OpB;
                            mulA   <= aExt;
                            mulB   <= bExt;
                            mulCnt <= '0;
                            if (isMulOp(Op)) begin
                                state <= MUL;
                                Busy  <= 1'b1;
                            end else if (isDivOp(Op)) begin
                                state <= DIV;
                                Busy  <= 1'b1;
                            end else if (Op == OP_MTHI) begin
                                Hi   <= OpA;
                                Done <= 1'b1;
                            end else if (Op == OP_MTLO) begin
                                Lo   <= OpA;
                                Done <= 1'b1;
                            end
                        end
                    end
                    MUL: begin
                        if (mulCnt == MulLast) begin
                            {Hi, Lo} <= mulRes;
                            state    <= IDLE;
                            Busy     <= 1'b0;
                            Done     <= 1'b1;
                        end else begin
                            mulCnt <= mulCnt + 1'b1;
                        end
                    end
                    DIV: begin
                        if (divLast) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        Hi    <= fixHi;
                        Lo    <= fixLo;
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, flush/reset sequences,
// and random ops checked against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    op_t         Op    = OP_MULT;
    logic [31:0] OpA   = '0;
    logic [31:0] OpB   = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] mHL;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    op_t opList[10] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                        OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU,
                        OP_MTHI, OP_MTLO};

    muldiv_unit #(
        .WIDTH(32),
        .MUL_LATENCY(2)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Op   (Op),
        .OpA  (OpA),
        .OpB  (OpB),
        .Flush(Flush),
        .Busy (Busy),
        .Done (Done),
        .Hi   (Hi),
        .Lo   (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on HI:LO
    function automatic logic [63:0] model(input op_t op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] hl);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              da, db;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        da = a;
        db = b;
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_MADD:  return hl + (sa * sb);
            OP_MADDU: return hl + (ua * ub);
            OP_MSUB:  return hl - (sa * sb);
            OP_MSUBU: return hl - (ua * ub);
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    return {32'h0, 32'h80000000};
                return {32'(da % db), 32'(da / db)};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, hl[31:0]};
            OP_MTLO: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    function automatic int expLat(input op_t op);
        if (op inside {OP_DIV, OP_DIVU}) return 33;
        if (op inside {OP_MTHI, OP_MTLO}) return 0;
        return 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the Done cycle
    task automatic runOp(input string tag, input op_t op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expHL, input int lat,
                         input bit poke);
        int n     = 0;
        int busyN = 0;
        bit got   = 0;
        Start = 1'b1;
        Op    = op;
        OpA   = a;
        OpB   = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        OpA   = $urandom;
        OpB   = $urandom;
        while (n < 60) begin
            @(negedge Clk);
            if (Done) begin
                got = 1;
                break;
            end
            if (Busy) busyN++;
            if (poke && Busy) begin
                Start = 1'b1;
                Op    = OP_MTLO;
                OpA   = $urandom;
            end
            @(posedge Clk);
            #1;
            Start = 1'b0;
            n++;
        end
        if (!got) @(negedge Clk);
        chk({tag, " done seen"}, 64'(got), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy cycles"}, 64'(busyN), 64'(lat));
        chk({tag, " busy at done"}, 64'(Busy), 64'd0);
        chk({tag, " hi"}, 64'(Hi), 64'(expHL[63:32]));
        chk({tag, " lo"}, 64'(Lo), 64'(expHL[31:0]));
    endtask

    initial begin
        logic [63:0] e;
        bit          seen;
        op_t         rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,
                     32'h00000001, 32'hFFFFFFFE, 2};
        vecs[2]  = '{OP_MTHI,  32'h0, 32'h0,
                     32'h0, 32'hFFFFFFFE, 0};
        vecs[3]  = '{OP_MTLO,  32'd5, 32'h0,
                     32'h0, 32'h5, 0};
        vecs[4]  = '{OP_MADD,  32'd3, 32'd4,
                     32'h0, 32'h11, 2};
        vecs[5]  = '{OP_MTLO,  32'h0, 32'h0,
                     32'h0, 32'h0, 0};
        vecs[6]  = '{OP_MSUB,  32'd3, 32'd4,
                     32'hFFFFFFFF, 32'hFFFFFFF4, 2};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[8]  = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,
                     32'h1, 32'h7FFFFFFC, 33};
        vecs[9]  = '{OP_DIV,   32'h1234, 32'h0,
                     32'h1234, 32'hFFFFFFFF, 33};
        vecs[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                     32'h0, 32'h80000000, 33};
        vecs[11] = '{OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h80000001, 2};
        vecs[12] = '{OP_MSUBU, 32'd1, 32'd1,
                     32'hFFFFFFFE, 32'h80000000, 2};
        vecs[13] = '{OP_DIVU,  32'd7, 32'h0,
                     32'h7, 32'hFFFFFFFF, 33};
        vecs[14] = '{OP_DIV,   32'd7, 32'hFFFFFFFE,
                     32'h1, 32'hFFFFFFFD, 33};

        #2 Reset = 1'b0;
        #1;
        chk("reset hi", 64'(Hi), 64'd0);
        chk("reset lo", 64'(Lo), 64'd0);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset done", 64'(Done), 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 15; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                  vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].lat,
                  (i == 7 || i == 8));
            if (i == 0) begin
                @(negedge Clk);
                chk("done one cycle", 64'(Done), 64'd0);
                chk("idle not busy", 64'(Busy), 64'd0);
            end
        end
        mHL = {vecs[14].hi, vecs[14].lo};

        // Flush in the middle of a divide
        mHL = model(OP_MTHI, 32'hAAAA5555, 0, mHL);
        runOp("pre mthi", OP_MTHI, 32'hAAAA5555, 0, mHL, 0, 0);
        mHL = model(OP_MTLO, 32'h1234ABCD, 0, mHL);
        runOp("pre mtlo", OP_MTLO, 32'h1234ABCD, 0, mHL, 0, 0);
        Start = 1'b1;
        Op    = OP_DIV;
        OpA   = 32'd100;
        OpB   = 32'd7;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        chk("busy before flush", 64'(Busy), 64'd1);
        Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        @(negedge Clk);
        chk("flush busy", 64'(Busy), 64'd0);
        seen = Done;
        repeat (40) begin
            @(negedge Clk);
            if (Done) seen = 1;
        end
        chk("flush no done", 64'(seen), 64'd0);
        chk("flush hi kept", 64'(Hi), 64'(mHL[63:32]));
        chk("flush lo kept", 64'(Lo), 64'(mHL[31:0]));

        // Flush and Start together: Start dropped
        Start = 1'b1;
        Flush = 1'b1;
        Op    = OP_MTLO;
        OpA   = 32'hDEAD;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Flush = 1'b0;
        @(negedge Clk);
        chk("flush+mtlo done", 64'(Done), 64'd0);
        chk("flush+mtlo lo", 64'(Lo), 64'(mHL[31:0]));
        Start = 1'b1;
        Flush = 1'b1;
        Op    = OP_MULT;
        OpA   = 32'd3;
        OpB   = 32'd3;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Flush = 1'b0;
        @(negedge Clk);
        chk("flush+mult busy", 64'(Busy), 64'd0);
        repeat (3) @(negedge Clk);
        chk("flush+mult hi", 64'(Hi), 64'(mHL[63:32]));

        // Asynchronous reset in the middle of a multiply
        Start = 1'b1;
        Op    = OP_MULT;
        OpA   = 32'h12345;
        OpB   = 32'h6789;
        @(posedge Clk);
        #1 Start = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("async rst hi", 64'(Hi), 64'd0);
        chk("async rst lo", 64'(Lo), 64'd0);
        chk("async rst busy", 64'(Busy), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        mHL = '0;
        mHL = model(OP_MULTU, 32'd7, 32'd9, mHL);
        runOp("post rst multu", OP_MULTU, 32'd7, 32'd9, mHL, 2, 0);
        mHL = model(OP_MADD, 32'hFFFFFFFF, 32'd5, mHL);
        runOp("post rst madd", OP_MADD, 32'hFFFFFFFF, 32'd5, mHL, 2, 0);

        // Random ops, back to back, against the model
        for (int k = 0; k < 80; k++) begin
            rop = opList[$urandom_range(9)];
            ra  = pick();
            rb  = pick();
            e   = model(rop, ra, rb, mHL);
            runOp($sformatf("rnd%0d op%0d %h %h", k, rop, ra, rb),
                  rop, ra, rb, e, expLat(rop), 0);
            mHL = e;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
